// File: rtl/legv8_multicycle_ctrl_pkg.sv
// legv8_ctrl_pkg: state encoding, opcode constants and control encodings for the multi-cycle LEGv8 controller
package legv8_ctrl_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM, S_WB_M, S_BRANCH, S_TRAP
  } state_t;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [1:0]  IMM_NONE = 2'b00;
  localparam logic [1:0]  IMM_D    = 2'b01;
  localparam logic [1:0]  IMM_CB   = 2'b10;
  localparam logic [1:0]  IMM_B    = 2'b11;
  localparam logic [1:0]  ALUOP_ADD   = 2'b00;
  localparam logic [1:0]  ALUOP_PASSB = 2'b01;
  localparam logic [1:0]  ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic r, ld, st, cbz, cbnz, b, bad;
  } iclass_t;
  function automatic logic [1:0] imm_of(iclass_t c);
    return (c.ld | c.st) ? IMM_D : (c.cbz | c.cbnz) ? IMM_CB : c.b ? IMM_B : IMM_NONE;
  endfunction
endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// legv8_ctrl_if: controller <-> datapath/memory signals; master is the controller side
interface legv8_ctrl_if #(parameter int ALUOP_W = 2, parameter int STATE_W = 4);
  logic [31:0] inst;
  logic zero, mem_ack;
  logic mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg2loc, mem_to_reg, alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0] imm_sel;
  logic illegal;
  logic [STATE_W-1:0] dbg_state;
  modport master(
    input inst, zero, mem_ack,
    output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg2loc, mem_to_reg, alu_src_b,
    output alu_op, imm_sel, illegal, dbg_state
  );
  modport slave(
    output inst, zero, mem_ack,
    input mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg2loc, mem_to_reg, alu_src_b,
    input alu_op, imm_sel, illegal, dbg_state
  );
endinterface

// File: rtl/legv8_multicycle_ctrl_inst_class.sv
// legv8_inst_class: combinational opcode classifier (opcode field inst[31:21])
module legv8_inst_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] op,
  output iclass_t     cls
);
  always_comb begin
    cls = '0;
    cls.r = op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR};
    cls.ld = op == OP_LDUR;
    cls.st = op == OP_STUR;
    cls.cbz = op[10:3] == OP_CBZ;
    cls.cbnz = op[10:3] == OP_CBNZ;
    cls.b = op[10:5] == OP_B;
    cls.bad = ~(cls.r | cls.ld | cls.st | cls.cbz | cls.cbnz | cls.b);
  end
endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/write-back of the multi-cycle LEGv8 datapath
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic rst,
  legv8_ctrl_if.master bus
);
  state_t state, state_n;
  iclass_t cls;
  logic ill;
  legv8_inst_class u_cls (.op(bus.inst[31:21]), .cls(cls));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_RESET;
    else state <= state_n;
  // illegal is raised on the way into S_TRAP so it is already high in the first trap cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) ill <= 1'b0;
    else if (state == S_DECODE && cls.bad) ill <= 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      S_RESET:  state_n = S_FETCH;
      S_FETCH:  state_n = bus.mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_n = cls.r ? S_EXEC_R : (cls.ld | cls.st) ? S_ADDR :
                          (cls.cbz | cls.cbnz | cls.b) ? S_BRANCH : S_TRAP;
      S_EXEC_R: state_n = S_WB_R;
      S_ADDR:   state_n = S_MEM;
      S_MEM:    state_n = !bus.mem_ack ? S_MEM : cls.st ? S_FETCH : S_WB_M;
      S_WB_R, S_WB_M, S_BRANCH: state_n = S_FETCH;
      default:  state_n = state;
    endcase
  end
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg2loc = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_b = 1'b0;
    bus.alu_op = ALUOP_W'(ALUOP_ADD);
    bus.imm_sel = IMM_NONE;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_write = bus.mem_ack;
        bus.pc_write = bus.mem_ack;
      end
      S_DECODE: begin
        bus.imm_sel = imm_of(cls);
        bus.reg2loc = ~cls.r;
      end
      S_EXEC_R: bus.alu_op = ALUOP_W'(ALUOP_FUNCT);
      S_WB_R: bus.reg_write = 1'b1;
      S_ADDR: begin
        bus.alu_src_b = 1'b1;
        bus.imm_sel = IMM_D;
        bus.reg2loc = 1'b1;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we = cls.st;
      end
      S_WB_M: begin
        bus.reg_write = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_op = ALUOP_W'(ALUOP_PASSB);
        bus.reg2loc = 1'b1;
        bus.pc_src = 1'b1;
        bus.imm_sel = imm_of(cls);
        bus.pc_write = cls.b | (cls.cbz & bus.zero) | (cls.cbnz & ~bus.zero);
      end
      default: ;
    endcase
  end
  assign bus.illegal = ill;
  assign bus.dbg_state = STATE_W'(state);
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: directed cycle tables plus randomized instruction streams checked against a per-instruction cycle-list model
module tb_legv8_multicycle_ctrl;
  import legv8_ctrl_pkg::*;
  // st, {req,we,irw,pcw,pcs,rw,r2l,m2r,asb}, alu_op, imm_sel, illegal
  typedef logic [17:0] out_t;
  typedef struct {
    string nm;
    logic [31:0] inst;
    logic ack;
    logic z;
    out_t e;
  } vec_t;
  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_CBNZ = 4, K_B = 5;
  localparam logic [31:0] I_ADD = 32'h8B020020, I_LDUR = 32'hF8408020, I_CBZ = 32'hB4000041;
  localparam logic [31:0] I_B = 32'h14000010, I_BAD = 32'hFFFFFFFF, I_STUR = 32'hF8000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  vec_t tab[$];
  vec_t q[$];
  legv8_ctrl_if bus ();
  legv8_multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic out_t v(state_t s, logic [8:0] f, logic [1:0] aop, logic [1:0] imm, logic ill);
    return {4'(s), f, aop, imm, ill};
  endfunction
  function automatic out_t act();
    return {bus.dbg_state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.reg_write, bus.reg2loc, bus.mem_to_reg, bus.alu_src_b, bus.alu_op, bus.imm_sel, bus.illegal};
  endfunction
  task automatic check(string nm, out_t e);
    out_t a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d flags=%b aop=%b imm=%b ill=%b, expected state=%0d flags=%b aop=%b imm=%b ill=%b",
               nm, a[17:14], a[13:5], a[4:3], a[2:1], a[0], e[17:14], e[13:5], e[4:3], e[2:1], e[0]);
    end
  endtask
  task automatic step(vec_t t);
    @(negedge clk);
    bus.inst = t.inst;
    bus.mem_ack = t.ack;
    bus.zero = t.z;
    #1;
    check(t.nm, t.e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    check("reset_asserted", v(S_RESET, 9'b0, 2'd0, 2'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_released", v(S_RESET, 9'b0, 2'd0, 2'd0, 1'b0));
  endtask
  // Model: one instruction expands into its expected cycle list from the sequencing rules
  task automatic gen(int k, logic [31:0] i, int fw, int mw, logic z);
    logic [1:0] imm;
    logic mem, cb, pw, r;
    imm = (k == K_LD || k == K_ST) ? 2'd1 : (k == K_CBZ || k == K_CBNZ) ? 2'd2 : k == K_B ? 2'd3 : 2'd0;
    mem = k == K_LD || k == K_ST;
    cb = k == K_CBZ || k == K_CBNZ || k == K_B;
    r = k == K_R;
    pw = k == K_B || (k == K_CBZ && z) || (k == K_CBNZ && !z);
    repeat (fw) q.push_back('{"rnd_fetch_wait", i, 1'b0, z, v(S_FETCH, 9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    q.push_back('{"rnd_fetch", i, 1'b1, z, v(S_FETCH, 9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    q.push_back('{"rnd_decode", i, 1'($urandom), z, v(S_DECODE, {6'b0, !r, 2'b0}, 2'd0, imm, 1'b0)});
    if (r) begin
      q.push_back('{"rnd_exec_r", i, 1'($urandom), z, v(S_EXEC_R, 9'b0, 2'd2, 2'd0, 1'b0)});
      q.push_back('{"rnd_wb_r", i, 1'($urandom), z, v(S_WB_R, 9'b0_0_0_0_0_1_0_0_0, 2'd0, 2'd0, 1'b0)});
    end
    if (mem) begin
      q.push_back('{"rnd_addr", i, 1'($urandom), z, v(S_ADDR, 9'b0_0_0_0_0_0_1_0_1, 2'd0, 2'd1, 1'b0)});
      repeat (mw) q.push_back('{"rnd_mem_wait", i, 1'b0, z, v(S_MEM, {1'b1, k == K_ST, 7'b0}, 2'd0, 2'd0, 1'b0)});
      q.push_back('{"rnd_mem", i, 1'b1, z, v(S_MEM, {1'b1, k == K_ST, 7'b0}, 2'd0, 2'd0, 1'b0)});
      if (k == K_LD) q.push_back('{"rnd_wb_m", i, 1'($urandom), z, v(S_WB_M, 9'b0_0_0_0_0_1_0_1_0, 2'd0, 2'd0, 1'b0)});
    end
    if (cb) q.push_back('{"rnd_branch", i, 1'($urandom), z, v(S_BRANCH, {3'b0, pw, 1'b1, 1'b0, 1'b1, 2'b0}, 2'd1, imm, 1'b0)});
  endtask
  initial begin
    logic [10:0] rops [4];
    logic [31:0] i;
    int k;
    rops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
    bus.inst = I_ADD;
    bus.mem_ack = 1'b1;
    bus.zero = 1'b0;
    // ADD with mem_ack tied high: FETCH, DECODE, EXEC_R, WB_R
    tab.push_back('{"add_fetch",  I_ADD, 1'b1, 1'b0, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"add_decode", I_ADD, 1'b1, 1'b0, v(S_DECODE, 9'b0_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"add_exec",   I_ADD, 1'b1, 1'b0, v(S_EXEC_R, 9'b0_0_0_0_0_0_0_0_0, 2'd2, 2'd0, 1'b0)});
    tab.push_back('{"add_wb",     I_ADD, 1'b1, 1'b0, v(S_WB_R,   9'b0_0_0_0_0_1_0_0_0, 2'd0, 2'd0, 1'b0)});
    // LDUR with three memory wait states: eight cycles in total
    tab.push_back('{"ld_fetch",   I_LDUR, 1'b1, 1'b0, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"ld_decode",  I_LDUR, 1'b0, 1'b0, v(S_DECODE, 9'b0_0_0_0_0_0_1_0_0, 2'd0, 2'd1, 1'b0)});
    tab.push_back('{"ld_addr",    I_LDUR, 1'b0, 1'b0, v(S_ADDR,   9'b0_0_0_0_0_0_1_0_1, 2'd0, 2'd1, 1'b0)});
    tab.push_back('{"ld_mem_w1",  I_LDUR, 1'b0, 1'b0, v(S_MEM,    9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"ld_mem_w2",  I_LDUR, 1'b0, 1'b0, v(S_MEM,    9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"ld_mem_w3",  I_LDUR, 1'b0, 1'b0, v(S_MEM,    9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"ld_mem_ack", I_LDUR, 1'b1, 1'b0, v(S_MEM,    9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"ld_wb",      I_LDUR, 1'b0, 1'b0, v(S_WB_M,   9'b0_0_0_0_0_1_0_1_0, 2'd0, 2'd0, 1'b0)});
    // CBZ taken then not taken
    tab.push_back('{"cbz1_fetch",  I_CBZ, 1'b1, 1'b1, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"cbz1_decode", I_CBZ, 1'b0, 1'b1, v(S_DECODE, 9'b0_0_0_0_0_0_1_0_0, 2'd0, 2'd2, 1'b0)});
    tab.push_back('{"cbz1_branch", I_CBZ, 1'b0, 1'b1, v(S_BRANCH, 9'b0_0_0_1_1_0_1_0_0, 2'd1, 2'd2, 1'b0)});
    tab.push_back('{"cbz0_fetch",  I_CBZ, 1'b1, 1'b0, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"cbz0_decode", I_CBZ, 1'b0, 1'b0, v(S_DECODE, 9'b0_0_0_0_0_0_1_0_0, 2'd0, 2'd2, 1'b0)});
    tab.push_back('{"cbz0_branch", I_CBZ, 1'b0, 1'b0, v(S_BRANCH, 9'b0_0_0_0_1_0_1_0_0, 2'd1, 2'd2, 1'b0)});
    // B is taken regardless of zero
    tab.push_back('{"b_fetch",  I_B, 1'b1, 1'b0, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    tab.push_back('{"b_decode", I_B, 1'b0, 1'b0, v(S_DECODE, 9'b0_0_0_0_0_0_1_0_0, 2'd0, 2'd3, 1'b0)});
    tab.push_back('{"b_branch", I_B, 1'b0, 1'b0, v(S_BRANCH, 9'b0_0_0_1_1_0_1_0_0, 2'd1, 2'd3, 1'b0)});
    tab.push_back('{"after_b",  I_B, 1'b0, 1'b0, v(S_FETCH,  9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    @(negedge clk);
    #1;
    check("reset_state", v(S_RESET, 9'b0, 2'd0, 2'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_last", v(S_RESET, 9'b0, 2'd0, 2'd0, 1'b0));
    for (int n = 0; n < tab.size(); n++) step(tab[n]);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 5);
      i = $urandom;
      case (k)
        K_R:    i[31:21] = rops[$urandom_range(0, 3)];
        K_LD:   i[31:21] = OP_LDUR;
        K_ST:   i[31:21] = OP_STUR;
        K_CBZ:  i[31:24] = OP_CBZ;
        K_CBNZ: i[31:24] = OP_CBNZ;
        default: i[31:26] = OP_B;
      endcase
      gen(k, i, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      while (q.size() > 0) step(q.pop_front());
    end
    // Illegal opcode: trap is sticky until reset
    step('{"trap_fetch",  I_BAD, 1'b1, 1'b0, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    step('{"trap_decode", I_BAD, 1'b0, 1'b0, v(S_DECODE, 9'b0_0_0_0_0_0_1_0_0, 2'd0, 2'd0, 1'b0)});
    for (int n = 0; n < 20; n++)
      step('{"trap_hold", I_BAD, 1'($urandom), 1'($urandom), v(S_TRAP, 9'b0, 2'd0, 2'd0, 1'b1)});
    do_reset();
    // Reset in the middle of a store access drops mem_req without waiting for a clock
    step('{"st_fetch",  I_STUR, 1'b1, 1'b0, v(S_FETCH,  9'b1_0_1_1_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    step('{"st_decode", I_STUR, 1'b0, 1'b0, v(S_DECODE, 9'b0_0_0_0_0_0_1_0_0, 2'd0, 2'd1, 1'b0)});
    step('{"st_addr",   I_STUR, 1'b0, 1'b0, v(S_ADDR,   9'b0_0_0_0_0_0_1_0_1, 2'd0, 2'd1, 1'b0)});
    step('{"st_mem",    I_STUR, 1'b0, 1'b0, v(S_MEM,    9'b1_1_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_mem", v(S_RESET, 9'b0, 2'd0, 2'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_hold", v(S_RESET, 9'b0, 2'd0, 2'd0, 1'b0));
    step('{"post_reset_fetch", I_ADD, 1'b0, 1'b0, v(S_FETCH, 9'b1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 1'b0)});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
